// File: rtl/mod1667_pkg.sv
// Shared constants and types for the q = 1667 modular datapath.
// FOLD_K is 1667 * 2^10, the constant subtracted by the 22-to-21-bit fold.
package mod1667_pkg;

   localparam int Q      = 1667;
   localparam int W_RES  = 11;
   localparam int W_PROD = 22;
   localparam int W_WIDE = 21;
   localparam int FOLD_K = 1707008;

   typedef logic [W_RES-1:0]  residue_t;
   typedef logic [W_PROD-1:0] prod_t;
   typedef logic [W_WIDE-1:0] wide_t;

endpackage

// File: rtl/mod1667_fold.sv
// Combinational conditional subtract that maps a 22-bit product of two residues
// onto a 21-bit value congruent mod 1667; shared with the future MAC stage.
module mod1667_fold
   import mod1667_pkg::*;
#(
   parameter prod_t K = prod_t'(FOLD_K)
) (
   input  prod_t p,
   output wide_t f
);

   prod_t sel;

   // For in-range operands the result is below 1068549, so dropping bit 21 loses nothing.
   always_comb begin
      sel = p;
      if (p >= K) begin
         sel = p - K;
      end
   end

   assign f = wide_t'(sel);

endmodule

// File: rtl/mod1667_mul_pipe.sv
// Two-stage pipelined modular-multiply front end for q = 1667 with valid/ready
// handshake; optional sticky operand range flag under MOD1667_RANGE_CHECK_EN.
module mod1667_mul_pipe
   import mod1667_pkg::*;
#(
   parameter int Q     = 1667,
   parameter int W_IN  = 11,
   parameter int W_OUT = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_a,
   input  logic [W_IN-1:0]  in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] dout_a
`ifdef MOD1667_RANGE_CHECK_EN
   ,
   output logic             err_range
`endif
);

   localparam prod_t FOLD_LOCAL = prod_t'(Q * 1024);

   logic  s1_valid;
   logic  s2_valid;
   prod_t p1;
   logic [W_OUT-1:0] p2;
   prod_t product;
   wide_t folded;
   logic  s1_adv;
   logic  s2_adv;
   logic  accept;

   // Each stage advances when it is empty or the stage after it is draining.
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign dout_a    = p2;

   assign product = prod_t'(in_a) * prod_t'(in_b);

   mod1667_fold #(
      .K(FOLD_LOCAL)
   ) u_fold (
      .p(p1),
      .f(folded)
   );

   // Data registers only load on a real transfer so a stalled output holds still.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         p1       <= '0;
         p2       <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               p1 <= product;
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               p2 <= W_OUT'(folded);
            end
         end
      end
   end

`ifdef MOD1667_RANGE_CHECK_EN
   // Sticky until reset; out-of-range data is still passed through unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_range <= 1'b0;
      end else if (accept && ((int'(in_a) >= Q) || (int'(in_b) >= Q))) begin
         err_range <= 1'b1;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_mod1667_mul_pipe.sv
// Scoreboard bench for mod1667_mul_pipe: stimulus pushes reference results,
// an independent monitor pops and compares on every output transfer.
module tb_mod1667_mul_pipe;

   typedef struct {
      int fold;
      int res;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] in_a = '0;
   logic [10:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [20:0] dout_a;
`ifdef MOD1667_RANGE_CHECK_EN
   logic        err_range;
`endif

   int   checks = 0;
   int   fails = 0;
   int   cycle = 0;
   int   accepts = 0;
   bit   rand_ready = 0;
   exp_t exp_q[$];
   int   out_cycles[$];

   mod1667_mul_pipe dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a(in_a),
      .in_b(in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .dout_a(dout_a)
`ifdef MOD1667_RANGE_CHECK_EN
      ,
      .err_range(err_range)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle = cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: the product, less 1667*1024 once if it reaches that value.
   function automatic exp_t refModel(input int a, input int b);
      exp_t e;
      int   p;
      p = a * b;
      if (p >= 1667 * 1024) p = p - 1667 * 1024;
      e.fold = p;
      e.res  = (a * b) % 1667;
      return e;
   endfunction

   task automatic applyStimulus(input int a, input int b);
      int waited;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a = a[10:0];
      in_b = b[10:0];
      #1;
      while (!in_ready) begin
         if (waited > 1000) begin
            checks++;
            fails++;
            $display("[TB] FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", waited);
            in_valid = 1'b0;
            return;
         end
         waited++;
         @(negedge clk);
         #1;
      end
      exp_q.push_back(refModel(a, b));
      accepts++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         #3;
         n++;
      end
      checkOutput(name, exp_q.size(), 0);
   endtask

   // Monitor: one look per cycle, well after the negedge when all inputs are settled.
   initial begin
      bit          held;
      logic [20:0] held_val;
      exp_t        e;
      held = 0;
      held_val = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid) begin
            if (held) checkOutput("dout_stable", dout_a, held_val);
            if (out_ready) begin
               held = 0;
               out_cycles.push_back(cycle);
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_output", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("dout_a", dout_a, e.fold);
                  checkOutput("dout_congruent", int'(dout_a) % 1667, e.res);
               end
            end else begin
               held = 1;
               held_val = dout_a;
            end
         end else begin
            held = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL global_timeout: simulation still running, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int a;
      int b;
      int first;

      // Reset held with in_valid asserted must not load anything.
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_a = 11'd5;
      in_b = 11'd7;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_dout", dout_a, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_in_ready", in_ready, 1);
      checkOutput("post_reset_out_valid", out_valid, 0);
`ifdef MOD1667_RANGE_CHECK_EN
      checkOutput("reset_err_range", err_range, 0);
`endif

      // Latency with an empty pipeline and the maximal operand pair.
      applyStimulus(1666, 1666);
      checkOutput("latency_edge1_valid", out_valid, 0);
      @(posedge clk);
      #1;
      checkOutput("latency_edge2_valid", out_valid, 1);
      checkOutput("max_operands_dout", dout_a, 1068548);
      waitDrain("drain_max");

      applyStimulus(1000, 1000);
      @(posedge clk);
      #1;
      checkOutput("no_fold_dout", dout_a, 1000000);
      waitDrain("drain_no_fold");

      // Back-to-back stream must come out on consecutive cycles.
      out_cycles.delete();
      applyStimulus(0, 5);
      applyStimulus(1, 1);
      applyStimulus(1666, 1);
      applyStimulus(3, 4);
      waitDrain("drain_stream");
      checkOutput("stream_count", out_cycles.size(), 4);
      if (out_cycles.size() == 4) begin
         first = out_cycles[0];
         checkOutput("stream_consecutive", out_cycles[3] - first, 3);
      end

      // Backpressure: only two pairs fit while the consumer stalls.
      @(negedge clk);
      out_ready = 1'b0;
      accepts = 0;
      fork
         begin
            applyStimulus(17, 23);
            applyStimulus(1666, 1500);
            applyStimulus(1234, 1665);
            applyStimulus(2, 3);
         end
         begin
            repeat (5) @(negedge clk);
            checkOutput("stall_accepts", accepts, 2);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_out_valid", out_valid, 1);
            out_ready = 1'b1;
         end
      join
      waitDrain("drain_backpressure");
      checkOutput("backpressure_accepts", accepts, 4);

      // Reset mid-flight discards everything in the pipe.
      @(negedge clk);
      out_ready = 1'b0;
      applyStimulus(100, 200);
      applyStimulus(300, 400);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midreset_out_valid", out_valid, 0);
      checkOutput("midreset_dout", dout_a, 0);
      checkOutput("midreset_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      checkOutput("midreset_no_output", out_valid, 0);

      // Random operands under random backpressure, with extremes mixed in.
      rand_ready = 1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0: a = 1666;
            1: a = 0;
            default: a = $urandom_range(0, 1666);
         endcase
         case ($urandom_range(0, 9))
            0: b = 1666;
            1: b = 1025 + $urandom_range(0, 641);
            default: b = $urandom_range(0, 1666);
         endcase
         applyStimulus(a, b);
      end
      waitDrain("drain_random");
      @(negedge clk);
      rand_ready = 0;
      out_ready = 1'b1;

`ifdef MOD1667_RANGE_CHECK_EN
      checkOutput("err_range_clear", err_range, 0);
      applyStimulus(1667, 2);
      checkOutput("err_range_set", err_range, 1);
      applyStimulus(3, 4);
      checkOutput("err_range_sticky", err_range, 1);
      waitDrain("drain_range");
`endif

      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
